// File: rtl/fu_complete_sender_pkg.sv
// Shared types and constants for the FU -> complete-stage result path.
// Bit i of every FU-indexed vector / field i of fu_state_packet_t refers to the same FU (bit 0 = alu_1).
package fu_complete_sender_pkg;

   localparam int XLEN          = 32;
   localparam int NUM_FU        = 8;
   localparam int FU_FIFO_DEPTH = 2;
   localparam int PR_W          = 5;

   // Packed LSB-first: alu_1 is bit 0 when the struct is viewed as a vector.
   typedef struct packed {
      logic store_1;
      logic load_1;
      logic branch_1;
      logic mult_2;
      logic mult_1;
      logic alu_3;
      logic alu_2;
      logic alu_1;
   } fu_state_packet_t;

   typedef struct packed {
      logic            valid;
      logic [PR_W-1:0] dest_pr;
      logic [XLEN-1:0] dest_value;
   } fu_complete_packet_t;

   function automatic fu_complete_packet_t mark_valid(input fu_complete_packet_t pkt);
      fu_complete_packet_t p;
      p       = pkt;
      p.valid = 1'b1;
      return p;
   endfunction

endpackage

// File: rtl/fu_complete_sender_if.sv
// Bundle of the FU result handshake and the complete-stage offer/stall signals.
interface fu_complete_sender_if
   import fu_complete_sender_pkg::*;
#(
   parameter int DEPTH = FU_FIFO_DEPTH
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   // Handshakes: an FU push happens on a rising edge where fu_out_valid[i] && fu_out_ready[i];
   // a head retires on a rising edge where fu_finish[i] && !fu_c_stall[i]. Ready, finish and
   // c_in come from registered state only, so neither consumer sees a combinational loop.
   logic                [NUM_FU-1:0]            fu_out_valid;
   fu_complete_packet_t [NUM_FU-1:0]            fu_out_pkt;
   logic                [NUM_FU-1:0]            fu_out_ready;
   fu_state_packet_t                            fu_c_stall;
   fu_state_packet_t                            fu_finish;
   fu_complete_packet_t [NUM_FU-1:0]            fu_c_in;
   logic                [NUM_FU-1:0][CNT_W-1:0] occupancy;

   modport sender (
      input  fu_out_valid,
      input  fu_out_pkt,
      input  fu_c_stall,
      output fu_out_ready,
      output fu_finish,
      output fu_c_in,
      output occupancy
   );

   modport receiver (
      output fu_out_valid,
      output fu_out_pkt,
      output fu_c_stall,
      input  fu_out_ready,
      input  fu_finish,
      input  fu_c_in,
      input  occupancy
   );

endinterface

// File: rtl/fu_result_fifo.sv
// Single-FU result FIFO: DEPTH entries, registered head/ready, synchronous squash on flush.
module fu_result_fifo
   import fu_complete_sender_pkg::*;
#(
   parameter int DEPTH = FU_FIFO_DEPTH
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            flush,
   input  logic                            push_i,
   input  fu_complete_packet_t             push_pkt_i,
   input  logic                            pop_i,
   output logic                            ready_o,
   output logic                            nonempty_o,
   output fu_complete_packet_t             head_o,
   output logic [$clog2(DEPTH+1)-1:0]      count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   fu_complete_packet_t        mem_q [DEPTH];
   logic [PTR_W-1:0]           head_q, head_d;
   logic [PTR_W-1:0]           tail_q, tail_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic                       do_push;
   logic                       do_pop;

   assign ready_o    = (count_q < CNT_W'(DEPTH));
   assign nonempty_o = (count_q != '0);
   assign head_o     = mem_q[head_q];
   assign count_o    = count_q;

   assign do_push = push_i && ready_o;
   assign do_pop  = pop_i && nonempty_o;

   // DEPTH is a power of two, so the pointer increment wraps on its own.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) tail_d = tail_q + PTR_W'(1);
         if (do_pop)  head_d = head_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: an empty FIFO's head is gated to zero by the top level.
   always_ff @(posedge clock) begin
      if (do_push && !flush) mem_q[tail_q] <= mark_valid(push_pkt_i);
   end

endmodule

// File: rtl/fu_complete_sender.sv
// Transmit side of the FU -> complete-stage interface: one result FIFO per FU, offered head-first.
module fu_complete_sender
   import fu_complete_sender_pkg::*;
#(
   parameter int DEPTH = FU_FIFO_DEPTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   fu_complete_sender_if.sender  bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                [NUM_FU-1:0]            stall_vec;
   logic                [NUM_FU-1:0]            ready_vec;
   logic                [NUM_FU-1:0]            nonempty_vec;
   fu_complete_packet_t [NUM_FU-1:0]            head_vec;
   logic                [NUM_FU-1:0][CNT_W-1:0] count_vec;
   fu_complete_packet_t [NUM_FU-1:0]            c_in_vec;

   assign stall_vec = bus.fu_c_stall;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
      fu_result_fifo #(
         .DEPTH (DEPTH)
      ) u_fifo (
         .clock      (clock),
         .reset      (reset),
         .flush      (flush),
         .push_i     (bus.fu_out_valid[i]),
         .push_pkt_i (bus.fu_out_pkt[i]),
         .pop_i      (!stall_vec[i]),
         .ready_o    (ready_vec[i]),
         .nonempty_o (nonempty_vec[i]),
         .head_o     (head_vec[i]),
         .count_o    (count_vec[i])
      );
   end

   // Stale storage must never leak onto the bus, so empty FIFOs present all-zero packets.
   always_comb begin
      c_in_vec = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (nonempty_vec[i]) c_in_vec[i] = head_vec[i];
      end
   end

   assign bus.fu_out_ready = ready_vec;
   assign bus.fu_finish    = fu_state_packet_t'(nonempty_vec);
   assign bus.fu_c_in      = c_in_vec;
   assign bus.occupancy    = count_vec;

endmodule

// File: tb/tb_fu_complete_sender.sv
// Directed scenarios followed by random traffic, checked against per-FU packet queues.
module tb_fu_complete_sender;
   import fu_complete_sender_pkg::*;

   localparam int DEPTH = 2;
   localparam int PKT_W = $bits(fu_complete_packet_t);

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;

   fu_complete_sender_if #(.DEPTH(DEPTH)) bus();

   fu_complete_sender #(.DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   // ---------------- scoreboard ----------------
   logic [PKT_W-1:0]    exp_q [NUM_FU][$];
   fu_complete_packet_t pkt_drv [NUM_FU];
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [NUM_FU-1:0]   fin;
      logic [PKT_W-1:0]    e;
      int                  sz;
      fin = bus.fu_finish;
      for (int i = 0; i < NUM_FU; i++) begin
         sz = exp_q[i].size();
         e  = (sz != 0) ? exp_q[i][0] : '0;
         chk($sformatf("%s finish[%0d]", tag, i), 64'(fin[i]), 64'(sz != 0));
         chk($sformatf("%s c_in[%0d]", tag, i), 64'(bus.fu_c_in[i]), 64'(e));
         chk($sformatf("%s occ[%0d]", tag, i), 64'(bus.occupancy[i]), 64'(sz));
         chk($sformatf("%s ready[%0d]", tag, i), 64'(bus.fu_out_ready[i]), 64'(sz < DEPTH));
      end
   endtask

   // ---------------- driver tasks ----------------
   function automatic fu_complete_packet_t mk_pkt(input logic [PR_W-1:0] pr, input logic [XLEN-1:0] val);
      fu_complete_packet_t p;
      p.valid      = 1'($urandom_range(0, 1));
      p.dest_pr    = pr;
      p.dest_value = val;
      return p;
   endfunction

   function automatic fu_complete_packet_t rand_pkt();
      return mk_pkt(PR_W'($urandom_range(0, 31)), $urandom);
   endfunction

   // One clock: drive at the falling edge, let the rising edge act, update model, check at next fall.
   task automatic cycle(input logic [NUM_FU-1:0] v, input logic [NUM_FU-1:0] stall,
                        input logic fl, input string tag, output logic [NUM_FU-1:0] acc);
      int sz;
      fu_complete_packet_t t;
      for (int i = 0; i < NUM_FU; i++) bus.fu_out_pkt[i] = pkt_drv[i];
      bus.fu_out_valid = v;
      bus.fu_c_stall   = fu_state_packet_t'(stall);
      flush            = fl;
      acc              = '0;
      @(posedge clock);
      for (int i = 0; i < NUM_FU; i++) begin
         if (fl) begin
            exp_q[i].delete();
         end else begin
            sz = exp_q[i].size();
            if (sz > 0 && !stall[i]) void'(exp_q[i].pop_front());
            if (v[i] && sz < DEPTH) begin
               t       = pkt_drv[i];
               t.valid = 1'b1;
               exp_q[i].push_back(PKT_W'(t));
               acc[i]  = 1'b1;
            end
         end
      end
      @(negedge clock);
      check_all(tag);
   endtask

   task automatic idle(input int n, input logic [NUM_FU-1:0] stall, input string tag);
      logic [NUM_FU-1:0] acc;
      for (int k = 0; k < n; k++) cycle('0, stall, 1'b0, tag, acc);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [NUM_FU-1:0] acc;
      logic [NUM_FU-1:0] v;
      logic [NUM_FU-1:0] st;
      logic [NUM_FU-1:0] held;
      logic [NUM_FU-1:0] fin;
      int tries;

      for (int i = 0; i < NUM_FU; i++) pkt_drv[i] = '0;
      bus.fu_out_valid = '0;
      bus.fu_out_pkt   = '0;
      bus.fu_c_stall   = '0;

      #1 reset = 1'b0;
      #2 check_all("reset");
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1 check_all("post_reset");
      @(negedge clock);

      // 1: single push on alu_1, popped at the first offer edge
      pkt_drv[0] = mk_pkt(5'h01, 32'h12345678);
      cycle(8'h01, 8'h00, 1'b0, "t1_push", acc);
      chk("t1 alu_1", 64'(bus.fu_finish.alu_1), 64'd1);
      chk("t1 pr", 64'(bus.fu_c_in[0].dest_pr), 64'h01);
      idle(1, 8'h00, "t1_pop");

      // 2: backpressure on FU 1; pr 4 is held by the FU until accepted
      pkt_drv[1] = mk_pkt(5'd2, 32'h2222);
      cycle(8'h02, 8'h02, 1'b0, "t2_p2", acc);
      pkt_drv[1] = mk_pkt(5'd3, 32'h3333);
      cycle(8'h02, 8'h02, 1'b0, "t2_p3", acc);
      chk("t2 occ1", 64'(bus.occupancy[1]), 64'd2);
      pkt_drv[1] = mk_pkt(5'd4, 32'h4444);
      cycle(8'h02, 8'h02, 1'b0, "t2_hold", acc);
      chk("t2 no_accept", 64'(acc[1]), 64'd0);
      tries = 0;
      do begin
         cycle(8'h02, 8'h00, 1'b0, "t2_drain", acc);
         tries++;
      end while (!acc[1] && tries < 8);
      chk("t2 accept_bound", 64'(acc[1]), 64'd1);
      idle(3, 8'h00, "t2_tail");

      // 3: steady push+pop at count 1 on FU 2 across pointer wrap
      pkt_drv[2] = rand_pkt();
      cycle(8'h04, 8'h00, 1'b0, "t3_seed", acc);
      for (int k = 0; k < 5; k++) begin
         pkt_drv[2] = rand_pkt();
         cycle(8'h04, 8'h00, 1'b0, "t3_pp", acc);
         chk("t3 occ2", 64'(bus.occupancy[2]), 64'd1);
      end
      idle(1, 8'h00, "t3_drain");

      // 4: FU 3 stalled while all FUs push once
      for (int i = 0; i < NUM_FU; i++) pkt_drv[i] = rand_pkt();
      cycle(8'hff, 8'h08, 1'b0, "t4_push", acc);
      idle(3, 8'h08, "t4_stalled");
      fin = bus.fu_finish;
      chk("t4 finish", 64'(fin), 64'h08);
      idle(1, 8'h00, "t4_release");

      // 5: flush with a concurrent push on FU 0
      for (int k = 0; k < 2; k++) begin
         pkt_drv[0] = rand_pkt();
         pkt_drv[5] = rand_pkt();
         cycle(8'h21, 8'hff, 1'b0, "t5_fill", acc);
      end
      pkt_drv[0] = rand_pkt();
      cycle(8'h01, 8'h00, 1'b1, "t5_flush", acc);
      fin = bus.fu_finish;
      chk("t5 finish", 64'(fin), 64'h00);

      // 6: asynchronous reset between edges with FIFOs occupied
      pkt_drv[4] = rand_pkt();
      pkt_drv[6] = rand_pkt();
      cycle(8'h50, 8'hff, 1'b0, "t6_fill", acc);
      bus.fu_out_valid = '0;
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < NUM_FU; i++) exp_q[i].delete();
      check_all("t6_async");
      @(negedge clock);
      reset = 1'b1;
      #1 check_all("t6_release");
      @(negedge clock);

      // random traffic; an unaccepted FU keeps its packet, as a real FU would
      held = '0;
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (!held[i]) pkt_drv[i] = rand_pkt();
            v[i]  = held[i] ? 1'b1 : 1'($urandom_range(0, 1));
            st[i] = ($urandom_range(0, 2) == 0);
         end
         cycle(v, st, ($urandom_range(0, 39) == 0), "rand", acc);
         held = v & ~acc & ~{NUM_FU{flush}};
      end
      idle(3, 8'h00, "final_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
